// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Video scan-out stage. Derives a 25 MHz pixel tick from the 50 MHz system
// clock and generates VGA timing from it (640x480@60 Hz at the defaults). It
// also walks the frame buffer read port in row-major order and expands each
// RGB332 pixel byte to 8 bits per channel for the video DAC.
//
// Ports
//   clk          in   50 MHz system clock
//   rst_n        in   asynchronous active-low reset
//   rd_addr      out  [18:0] frame buffer read address
//   rd_data      in   [7:0]  frame buffer read data, {R[2:0],G[2:0],B[1:0]}
//   vga_r/g/b    out  [7:0]  pixel colour, 0 outside the visible area
//   vga_hs       out  horizontal sync, active low
//   vga_vs       out  vertical sync, active low
//   vga_blank_n  out  high during visible pixels
//   vga_sync_n   out  constant 0
//   vga_clk      out  25 MHz pixel clock (equals the internal tick)
//   frame_start  out  one-clk pulse after each frame wrap
// ---------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries pre-sized to the 10-bit counters.
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        tick;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [18:0] addr_cnt;

  logic active;
  logic h_last;
  logic v_last;
  logic in_hsync;
  logic in_vsync;

  assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign in_hsync = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign in_vsync = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  assign rd_addr    = addr_cnt;
  assign vga_clk    = tick;
  assign vga_sync_n = 1'b0;

  // NOTE: every register here uses non-blocking assignment so all of them
  // see the pre-edge values of tick/h_cnt/v_cnt; blocking assignment would
  // make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick        <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      addr_cnt    <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick <= ~tick;
      // The edge after the wrapping tick always has tick==0, so this clears
      // itself one clk later.
      frame_start <= tick && h_last && v_last;

      if (tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end

        // Incrementing only on visible pixels keeps addr_cnt equal to
        // v_cnt*H_ACTIVE + h_cnt without a multiplier; during blanking it
        // simply holds.
        if (h_last && v_last) begin
          addr_cnt <= '0;
        end else if (active) begin
          addr_cnt <= addr_cnt + 19'd1;
        end

        // rd_data here belongs to the address issued one pixel earlier,
        // so this stage lines up with the counters' previous position.
        vga_blank_n <= active;
        vga_hs      <= !in_hsync;
        vga_vs      <= !in_vsync;
        if (active) begin
          vga_r <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
          vga_g <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
          vga_b <= {rd_data[1:0], rd_data[1:0], rd_data[1:0], rd_data[1:0]};
        end else begin
          vga_r <= '0;
          vga_g <= '0;
          vga_b <= '0;
        end
      end
    end
  end

endmodule
